// File: rtl/swap_pipe.sv
// swap_pipe: lane-swap transform applied at the input, results buffered in a 2-entry FIFO.
// Latency: 1 cycle from input accept to out_valid when the FIFO is empty.
// Backpressure: in_ready is registered and means "fewer than 2 entries stored"; a pop never frees space in the same cycle.
//
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   in_valid/in_ready   - input handshake; in_data/in_mode sampled on transfer
//   out_valid/out_ready - output handshake; out_data is the oldest stored word
//   beat_count          - saturating count of delivered beats whose mode was non-zero
module swap_pipe #(
  parameter int WIDTH = 32,
  parameter int LANE  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [15:0]      beat_count
);

  localparam int N = WIDTH / LANE;

  // Pair swaps and half swaps both need an even lane split of the word.
  if ((WIDTH % (2 * LANE)) != 0) begin : g_bad_width
    $error("swap_pipe: WIDTH must be a multiple of 2*LANE");
  end

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

  typedef struct packed {
    logic [1:0]       mode;
    logic [WIDTH-1:0] data;
  } entry_t;

  occ_t         occ;
  entry_t       mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         in_ready_q;
  logic         out_valid_q;
  logic [15:0]  beat_cnt;
  logic [WIDTH-1:0] swapped;
  logic         push;
  logic         pop;

  // Lane k of the result is taken from the source lane chosen by the mode.
  always_comb begin
    swapped = in_data;
    for (int k = 0; k < N; k++) begin
      unique case (in_mode)
        2'd1:    swapped[k*LANE +: LANE] = in_data[(N-1-k)*LANE +: LANE];
        2'd2:    swapped[k*LANE +: LANE] = in_data[(k^1)*LANE +: LANE];
        2'd3:    swapped[k*LANE +: LANE] = in_data[((k+N/2)%N)*LANE +: LANE];
        default: swapped[k*LANE +: LANE] = in_data[k*LANE +: LANE];
      endcase
    end
  end

  assign push = in_valid && in_ready_q;
  assign pop  = out_valid_q && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ         <= EMPTY;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      beat_cnt    <= 16'd0;
      mem[0]      <= '0;
      mem[1]      <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{mode: in_mode, data: swapped};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
        if (mem[rd_ptr].mode != 2'd0 && beat_cnt != 16'hFFFF)
          beat_cnt <= beat_cnt + 16'd1;
      end
      // Handshake flags are registered alongside the occupancy so neither
      // depends combinationally on in_valid or out_ready.
      unique case (occ)
        EMPTY: begin
          in_ready_q <= 1'b1;  // also raises in_ready on the first edge after reset
          if (push) begin
            occ         <= ONE;
            out_valid_q <= 1'b1;
          end
        end
        ONE: begin
          if (push && !pop) begin
            occ        <= FULL;
            in_ready_q <= 1'b0;
          end else if (!push && pop) begin
            occ         <= EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        FULL: begin
          // in_ready is low here, so only a pop can change occupancy.
          if (pop) begin
            occ        <= ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          occ         <= EMPTY;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_data   = mem[rd_ptr].data;
  assign beat_count = beat_cnt;

endmodule

// File: tb/tb_swap_pipe.sv
module tb_swap_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [1:0]  in_mode = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [15:0] beat_count;

  logic        v64 = 1'b0;
  logic        r64;
  logic [63:0] d64 = '0;
  logic [1:0]  m64 = '0;
  logic        ov64;
  logic        ordy64 = 1'b1;
  logic [63:0] od64;
  logic [15:0] bc64;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  swap_pipe #(.WIDTH(32), .LANE(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .beat_count(beat_count)
  );

  swap_pipe #(.WIDTH(64), .LANE(16)) u64 (
    .clk(clk), .rst(rst),
    .in_valid(v64), .in_ready(r64), .in_data(d64), .in_mode(m64),
    .out_valid(ov64), .out_ready(ordy64), .out_data(od64),
    .beat_count(bc64)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference transform written as whole-word arithmetic for 8-bit lanes.
  function automatic logic [31:0] mswap(input logic [31:0] x, input logic [1:0] m);
    logic [31:0] r;
    case (m)
      2'd1:    r = {<<8{x}};
      2'd2:    r = ((x & 32'h00ff00ff) << 8) | ((x >> 8) & 32'h00ff00ff);
      2'd3:    r = {x[15:0], x[31:16]};
      default: r = x;
    endcase
    return r;
  endfunction

  // Behavioural model: a queue of at most two {data, mode} entries.
  typedef struct { logic [31:0] data; logic [1:0] mode; } ment_t;
  ment_t       mq[$];
  logic        m_rdy = 1'b0;
  logic [15:0] m_cnt = 16'd0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_rdy = 1'b0;
      m_cnt = 16'd0;
    end else begin
      logic   acc_in;
      logic   acc_out;
      ment_t  e;
      acc_in  = in_valid && m_rdy;
      acc_out = (mq.size() > 0) && out_ready;
      if (acc_out) begin
        e = mq.pop_front();
        if (e.mode != 2'd0 && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end
      if (acc_in) begin
        e.data = mswap(in_data, in_mode);
        e.mode = in_mode;
        mq.push_back(e);
      end
      m_rdy = (mq.size() < 2);
    end
  end

  // Per-cycle comparison of the 32-bit instance against the model.
  always @(negedge clk) begin
    check("in_ready", {63'd0, in_ready}, {63'd0, m_rdy});
    check("out_valid", {63'd0, out_valid}, {63'd0, (mq.size() > 0)});
    if (mq.size() > 0) check("out_data", {32'd0, out_data}, {32'd0, mq[0].data});
    check("beat_count", {48'd0, beat_count}, {48'd0, m_cnt});
  end

  // Record every delivered output word.
  logic [31:0] got[$];
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) got.push_back(out_data);
  end

  // Offer one beat and hold it until accepted (bounded).
  task automatic send(input logic [31:0] d, input logic [1:0] m);
    logic acc;
    acc = 1'b0;
    in_data  = d;
    in_mode  = m;
    in_valid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    if (!acc) check("send_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp32 [4];
    int          n;
    exp32[0] = 32'hdeadbeef; exp32[1] = 32'hefbeadde;
    exp32[2] = 32'haddeefbe; exp32[3] = 32'hbeefdead;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_data", {32'd0, out_data}, 64'd0);
    check("rst_beat_count", {48'd0, beat_count}, 64'd0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

    // Four modes on consecutive cycles, downstream always ready
    out_ready = 1'b1;
    in_data   = 32'hdeadbeef;
    for (int i = 0; i < 4; i++) begin
      in_mode  = 2'(i);
      in_valid = 1'b1;
      @(posedge clk); #1;
      check("mode_out_valid", {63'd0, out_valid}, 64'd1);
      check("mode_out_data", {32'd0, out_data}, {32'd0, exp32[i]});
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("mode_beat_count", {48'd0, beat_count}, 64'd3);

    // Backpressure: two fill the FIFO, the third is held by the source
    out_ready = 1'b0;
    got.delete();
    send(32'h01234567, 2'd1);
    send(32'h89abcdef, 2'd2);
    check("full_in_ready", {63'd0, in_ready}, 64'd0);
    fork
      send(32'hcafef00d, 2'd3);
      begin
        repeat (3) begin
          @(posedge clk); #1;
          check("hold_out_valid", {63'd0, out_valid}, 64'd1);
          check("hold_out_data", {32'd0, out_data}, 64'h67452301);
          check("hold_in_ready", {63'd0, in_ready}, 64'd0);
        end
        out_ready = 1'b1;
      end
    join
    repeat (3) @(posedge clk);
    #1;
    check("bp_count", got.size(), 64'd3);
    if (got.size() == 3) begin
      check("bp_order0", {32'd0, got[0]}, 64'h67452301);
      check("bp_order1", {32'd0, got[1]}, 64'hab89efcd);
      check("bp_order2", {32'd0, got[2]}, 64'hf00dcafe);
    end

    // Streaming at occupancy ONE: push and pop every cycle
    got.delete();
    for (int i = 0; i < 21; i++) begin
      send(32'h1000 + i, 2'(i % 4));
      if (i > 0) begin
        check("stream_in_ready", {63'd0, in_ready}, 64'd1);
        check("stream_out_valid", {63'd0, out_valid}, 64'd1);
      end
    end
    @(posedge clk); #1;
    check("stream_count", got.size(), 64'd21);
    n = got.size();
    if (n > 0) check("stream_last", {32'd0, got[n-1]}, 64'h00001014);

    // Asynchronous reset with two beats stored
    out_ready = 1'b0;
    send(32'h11111111, 2'd1);
    send(32'h22222222, 2'd2);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_out_valid", {63'd0, out_valid}, 64'd0);
    check("arst_in_ready", {63'd0, in_ready}, 64'd0);
    check("arst_beat_count", {48'd0, beat_count}, 64'd0);
    check("arst_out_data", {32'd0, out_data}, 64'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    out_ready = 1'b1;
    got.delete();
    repeat (4) @(posedge clk);
    #1;
    check("arst_no_stale", got.size(), 64'd0);
    check("arst_idle_valid", {63'd0, out_valid}, 64'd0);

    // 64-bit / 16-bit lane instance: lane reverse and counter saturation
    d64 = 64'h0011223344556677;
    m64 = 2'd1;
    v64 = 1'b1;
    @(posedge clk); #1;
    v64 = 1'b0;
    check("w64_valid", {63'd0, ov64}, 64'd1);
    check("w64_data", od64, 64'h6677445522330011);
    @(posedge clk); #1;
    check("w64_count1", {48'd0, bc64}, 64'd1);
    force u64.beat_cnt = 16'hFFFE;
    #1 release u64.beat_cnt;
    check("w64_forced", {48'd0, bc64}, 64'hFFFE);
    v64 = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    v64 = 1'b0;
    @(posedge clk); #1;
    check("w64_sat", {48'd0, bc64}, 64'hFFFF);
    repeat (2) @(posedge clk);
    #1;
    check("w64_sat_hold", {48'd0, bc64}, 64'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/swap_pipe.md
SWAP_PIPE -- requirements
Module: swap_pipe

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, giving the data width in bits.
REQ-002 The module SHALL have parameter LANE, default 8, giving the lane width in bits; WIDTH SHALL be a multiple of 2*LANE, and elaboration SHALL fail otherwise.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The module SHALL have port in_valid, input, 1 bit: the input beat is valid.
REQ-006 The module SHALL have port in_ready, output, 1 bit: the block accepts an input beat this cycle.
REQ-007 The module SHALL have port in_data, input, WIDTH bits: the input word.
REQ-008 The module SHALL have port in_mode, input, 2 bits: the swap mode for the input beat.
REQ-009 The module SHALL have port out_valid, output, 1 bit: the output beat is valid.
REQ-010 The module SHALL have port out_ready, input, 1 bit: the downstream accepts the output beat.
REQ-011 The module SHALL have port out_data, output, WIDTH bits: the swapped word.
REQ-012 The module SHALL have port beat_count, output, 16 bits: the count of swapped beats delivered.

Function
REQ-013 The block SHALL apply the swap transform combinationally at input, using the in_mode value of the same beat, and SHALL store the result in a 2-entry FIFO.
REQ-014 Mode 0 SHALL pass the word unchanged.
REQ-015 Mode 1 SHALL reverse the order of all lanes (lane k goes to lane N-1-k, where N = WIDTH/LANE).
REQ-016 Mode 2 SHALL swap adjacent lane pairs (lane 2j goes to 2j+1 and lane 2j+1 goes to 2j).
REQ-017 Mode 3 SHALL swap the upper and lower WIDTH/2 halves, with lane order inside each half preserved.
REQ-018 An input transfer SHALL occur when in_valid && in_ready, and an output transfer SHALL occur when out_valid && out_ready.
REQ-019 in_ready SHALL be 1 iff the FIFO holds fewer than 2 entries (registered occupancy), with no combinational path from out_ready or in_valid.
REQ-020 out_valid SHALL be 1 iff the FIFO holds at least 1 entry, and out_data SHALL be the oldest entry.
REQ-021 Latency SHALL be 1 cycle: a beat accepted at edge t SHALL be presented with out_valid=1 after edge t if the FIFO was empty.
REQ-022 Order SHALL be preserved, and no beat SHALL be dropped or duplicated.
REQ-023 On a simultaneous push and pop, occupancy SHALL be unchanged and the new entry SHALL queue behind the remaining entry.
REQ-024 When full, in_ready=0; a pop in that cycle SHALL NOT enable a push in the same cycle.
REQ-025 While out_valid=1 and out_ready=0, out_data and out_valid SHALL hold stable.
REQ-026 Occupancy state SHALL take the values EMPTY(0), ONE(1) or FULL(2): push-only increments, pop-only decrements, push+pop or neither holds.
REQ-027 beat_count SHALL increment by 1 on each output transfer whose stored mode != 0, and SHALL saturate at 16'hFFFF.
REQ-028 Each FIFO entry SHALL store its mode (2 bits) alongside its data for the beat_count rule.

Reset
REQ-029 While rst=1, asynchronously: occupancy = EMPTY, out_valid=0, in_ready=0, beat_count=0, out_data=0.
REQ-030 On the first edge after rst deasserts, in_ready SHALL be 1.
REQ-031 Reset mid-operation SHALL discard all stored beats; no partial beat SHALL emerge after reset.

Verification
REQ-032 WIDTH=32, LANE=8, out_ready=1, in_data=32'hdeadbeef, modes 0/1/2/3 on consecutive cycles -> out_data deadbeef, efbeadde, addeefbe, beefdead on consecutive cycles, each 1 cycle after accept; beat_count=3.
REQ-033 out_ready=0, push 3 beats back-to-back -> 2 accepted, in_ready=0 from the cycle after the second accept, third held by the source; out_data stable; release out_ready -> all 3 emerge in order.
REQ-034 FIFO at ONE, in_valid=1 and out_ready=1 continuously for 20 cycles -> 1 beat per cycle, occupancy stays ONE, in_ready=1 throughout.
REQ-035 Assert rst asynchronously (between edges) with 2 beats stored -> out_valid and in_ready drop immediately, beat_count=0; after release, no stale beat emerges.
REQ-036 WIDTH=64, LANE=16, mode 1, in_data=64'h0011223344556677 -> 64'h6677445522330011; force beat_count to 16'hFFFE, then 3 mode-1 beats -> 16'hFFFF held.
REQ-037 Elaborate with WIDTH=24, LANE=8 -> elaboration error.
